fft_config_sink: RTL and testbench

//  AXI-Stream slave at the far end of the FFT/IFFT configuration channel. Accepts 16-bit config

---
 rtl/fft_config_sink.sv | 121 ++++++++++++
 tb/tb_fft_config_sink.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_config_sink.sv
// rtl/fft_config_sink.sv - FFT config channel sink applying words at data frame boundaries
module fft_config_sink #(
  parameter int         LOG2_NFFT     = 6,
  parameter logic       RST_FWD_INV   = 1'b0,
  parameter logic [7:0] RST_SCALE_SCH = 8'b01_10_10_10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] s_axis_config_tdata,
  input  logic        s_axis_config_tvalid,
  output logic        s_axis_config_tready,
  input  logic        data_tvalid,
  input  logic        data_tready,
  input  logic        data_tlast,
  output logic        cfg_fwd_inv,
  output logic [7:0]  cfg_scale_sch,
  output logic        cfg_valid,
  output logic        cfg_pending,
  output logic        evt_pad_err,
  output logic        evt_tlast_early,
  output logic        evt_tlast_missing
);

  typedef enum logic [1:0] {NO_CFG, IDLE, FRAME} state_t;

  localparam logic [LOG2_NFFT-1:0] LAST_IDX = '1;
  localparam logic [LOG2_NFFT-1:0] ONE      = LOG2_NFFT'(1);

  state_t               state, state_next;
  logic [LOG2_NFFT-1:0] cnt;
  logic [8:0]           pend_word;
  logic                 pending_next;

  logic accept, beat, at_last, frame_end, boundary, apply;

  assign accept    = s_axis_config_tvalid & s_axis_config_tready;
  assign beat      = data_tvalid & data_tready;
  assign at_last   = (cnt == LAST_IDX);
  assign frame_end = beat & (data_tlast | at_last);
  // A word may only take effect while no frame is in flight.
  assign boundary  = ((cnt == '0) & ~beat) | frame_end;
  // Only a word already sitting in the buffer applies; a word accepted this cycle waits one edge.
  assign apply     = cfg_pending & boundary;

  // State register for cfg_valid / in-frame tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= NO_CFG;
    else        state <= state_next;
  end

  // Next-state logic; cfg_valid is decoded from the state.
  always_comb begin
    state_next = state;
    cfg_valid  = 1'b1;
    case (state)
      NO_CFG: begin
        cfg_valid = 1'b0;
        if (apply) state_next = IDLE;
      end
      IDLE: begin
        if (beat && !frame_end) state_next = FRAME;
      end
      FRAME: begin
        if (frame_end) state_next = IDLE;
      end
      default: state_next = NO_CFG;
    endcase
  end

  // Data beat counter; any frame-ending beat returns it to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cnt <= '0;
    else if (frame_end) cnt <= '0;
    else if (beat)      cnt <= cnt + ONE;
  end

  // Framing error pulses, one cycle after the offending beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_tlast_early   <= 1'b0;
      evt_tlast_missing <= 1'b0;
    end else begin
      evt_tlast_early   <= beat & data_tlast & ~at_last;
      evt_tlast_missing <= beat & ~data_tlast & at_last;
    end
  end

  // One-entry pending buffer: apply and accept never coincide because tready is low while full.
  always_comb begin
    pending_next = cfg_pending;
    if (apply)       pending_next = 1'b0;
    else if (accept) pending_next = 1'b1;
  end

  // Pending word capture, pad-bit check, and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_word            <= '0;
      cfg_pending          <= 1'b0;
      s_axis_config_tready <= 1'b0;
      evt_pad_err          <= 1'b0;
    end else begin
      if (accept) pend_word <= {s_axis_config_tdata[8:1], s_axis_config_tdata[0]};
      cfg_pending          <= pending_next;
      s_axis_config_tready <= ~pending_next;
      evt_pad_err          <= accept & (|s_axis_config_tdata[15:9]);
    end
  end

  // Held configuration outputs, updated only when a pending word applies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_fwd_inv   <= RST_FWD_INV;
      cfg_scale_sch <= RST_SCALE_SCH;
    end else if (apply) begin
      cfg_fwd_inv   <= pend_word[0];
      cfg_scale_sch <= pend_word[8:1];
    end
  end

endmodule

// File: tb/tb_fft_config_sink.sv
// tb/tb_fft_config_sink.sv - self-checking bench for fft_config_sink
module tb_fft_config_sink;

  typedef struct {
    logic [15:0] tdata;
    logic [7:0]  exp_scale;
    logic        exp_fwd;
    logic        exp_pad;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cfg_tdata = '0;
  logic        cfg_tvalid = 1'b0;
  logic        s_axis_config_tready;
  logic        data_tvalid = 1'b0;
  logic        data_tready = 1'b0;
  logic        data_tlast = 1'b0;
  logic        cfg_fwd_inv;
  logic [7:0]  cfg_scale_sch;
  logic        cfg_valid;
  logic        cfg_pending;
  logic        evt_pad_err;
  logic        evt_tlast_early;
  logic        evt_tlast_missing;

  int         tests = 0;
  int         fails = 0;
  logic [8:0] sbq[$];
  int         m_cnt = 0;
  logic       mon_prev = 1'b0;
  vec_t       tbl[5];

  always #5 clk = ~clk;

  fft_config_sink dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .s_axis_config_tdata  (cfg_tdata),
    .s_axis_config_tvalid (cfg_tvalid),
    .s_axis_config_tready (s_axis_config_tready),
    .data_tvalid          (data_tvalid),
    .data_tready          (data_tready),
    .data_tlast           (data_tlast),
    .cfg_fwd_inv          (cfg_fwd_inv),
    .cfg_scale_sch        (cfg_scale_sch),
    .cfg_valid            (cfg_valid),
    .cfg_pending          (cfg_pending),
    .evt_pad_err          (evt_pad_err),
    .evt_tlast_early      (evt_tlast_early),
    .evt_tlast_missing    (evt_tlast_missing)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus; the bench's own beat model predicts the event pulses.
  task automatic cyc(input logic cv, input logic [15:0] cd, input logic dv, input logic dl);
    logic acc, e_early, e_miss;
    cfg_tvalid = cv; cfg_tdata = cd;
    data_tvalid = dv; data_tready = dv; data_tlast = dl;
    #1;
    acc     = cv && s_axis_config_tready;
    e_early = dv && dl && (m_cnt != 63);
    e_miss  = dv && !dl && (m_cnt == 63);
    if (acc) sbq.push_back({cd[8:1], cd[0]});
    @(posedge clk); #1;
    if (dv) m_cnt = (dl || m_cnt == 63) ? 0 : m_cnt + 1;
    check("evt_pad_err", evt_pad_err, acc && (|cd[15:9]));
    check("evt_tlast_early", evt_tlast_early, e_early);
    check("evt_tlast_missing", evt_tlast_missing, e_miss);
    cfg_tvalid = 1'b0; cfg_tdata = '0;
    data_tvalid = 1'b0; data_tready = 1'b0; data_tlast = 1'b0;
  endtask

  // Scoreboard: every pending->applied transition must deliver the oldest accepted word.
  always @(negedge clk) begin
    logic [8:0] exp;
    if (!rst_n) begin
      mon_prev = 1'b0;
    end else begin
      if (mon_prev && !cfg_pending) begin
        if (sbq.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          exp = sbq.pop_front();
          check("sb_scale", cfg_scale_sch, exp[8:1]);
          check("sb_fwd", cfg_fwd_inv, exp[0]);
          check("sb_valid", cfg_valid, 1'b1);
        end
      end
      mon_prev = cfg_pending;
    end
  end

  initial begin
    logic [7:0] prev_scale;
    tbl[0] = '{16'h00D5, 8'h6A, 1'b1, 1'b0};
    tbl[1] = '{16'h0002, 8'h01, 1'b0, 1'b0};
    tbl[2] = '{16'hFE00, 8'h00, 1'b0, 1'b1};
    tbl[3] = '{16'h01FF, 8'hFF, 1'b1, 1'b0};
    tbl[4] = '{16'h0201, 8'h00, 1'b1, 1'b1};

    // Reset state
    @(posedge clk); #1;
    check("rst_tready", s_axis_config_tready, 1'b0);
    check("rst_fwd", cfg_fwd_inv, 1'b0);
    check("rst_scale", cfg_scale_sch, 8'h6A);
    check("rst_valid", cfg_valid, 1'b0);
    check("rst_pending", cfg_pending, 1'b0);
    check("rst_evts", {evt_pad_err, evt_tlast_early, evt_tlast_missing}, 3'b000);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_tready", s_axis_config_tready, 1'b1);

    // Table: words accepted while idle apply two edges after acceptance
    prev_scale = 8'h6A;
    for (int i = 0; i < 5; i++) begin
      check("tv_tready_pre", s_axis_config_tready, 1'b1);
      cyc(1'b1, tbl[i].tdata, 1'b0, 1'b0);
      check("tv_pad", evt_pad_err, tbl[i].exp_pad);
      check("tv_pending", cfg_pending, 1'b1);
      check("tv_tready_busy", s_axis_config_tready, 1'b0);
      check("tv_scale_hold", cfg_scale_sch, prev_scale);
      cyc(1'b0, 16'h0, 1'b0, 1'b0);
      check("tv_scale", cfg_scale_sch, tbl[i].exp_scale);
      check("tv_fwd", cfg_fwd_inv, tbl[i].exp_fwd);
      check("tv_valid", cfg_valid, 1'b1);
      check("tv_tready", s_axis_config_tready, 1'b1);
      prev_scale = tbl[i].exp_scale;
    end

    // Word accepted at beat 10 waits for the TLAST on beat 63
    for (int k = 0; k < 64; k++) begin
      cyc(k == 10, 16'h0002, 1'b1, k == 63);
      if (k == 30) begin
        check("mid_pending", cfg_pending, 1'b1);
        check("mid_tready", s_axis_config_tready, 1'b0);
        check("mid_scale_hold", cfg_scale_sch, 8'h00);
      end
    end
    check("f2_scale", cfg_scale_sch, 8'h01);
    check("f2_fwd", cfg_fwd_inv, 1'b0);
    check("f2_tready", s_axis_config_tready, 1'b1);

    // Early TLAST on beat 20 ends the frame and applies the pending word
    for (int k = 0; k <= 20; k++) cyc(k == 5, 16'h00D5, 1'b1, k == 20);
    check("early_pulse", evt_tlast_early, 1'b1);
    check("early_scale", cfg_scale_sch, 8'h6A);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);

    // 64 beats without TLAST, then a single-beat frame on index 0
    for (int k = 0; k < 64; k++) cyc(1'b0, 16'h0, 1'b1, 1'b0);
    check("missing_pulse", evt_tlast_missing, 1'b1);
    cyc(1'b0, 16'h0, 1'b1, 1'b1);
    check("idx0_early", evt_tlast_early, 1'b1);
    check("idx0_missing", evt_tlast_missing, 1'b0);

    // Accept on the first beat of a frame: frame runs on the old config
    cyc(1'b1, 16'h0003, 1'b1, 1'b0);
    for (int k = 1; k < 64; k++) begin
      cyc(1'b0, 16'h0, 1'b1, k == 63);
      if (k == 32) check("first_beat_hold", cfg_scale_sch, 8'h6A);
    end
    check("first_beat_scale", cfg_scale_sch, 8'h01);
    check("first_beat_fwd", cfg_fwd_inv, 1'b1);

    // Accept on the frame-ending beat: applies on the following edge
    for (int k = 0; k < 10; k++) cyc(1'b0, 16'h0, 1'b1, 1'b0);
    cyc(1'b1, 16'h0004, 1'b1, 1'b1);
    check("end_beat_hold", cfg_scale_sch, 8'h01);
    check("end_beat_pending", cfg_pending, 1'b1);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    check("end_beat_scale", cfg_scale_sch, 8'h02);
    check("end_beat_fwd", cfg_fwd_inv, 1'b0);

    // Reset mid-frame with a word pending
    for (int k = 0; k < 10; k++) cyc(k == 3, 16'h01FF, 1'b1, 1'b0);
    check("pre_rst_pending", cfg_pending, 1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_fwd", cfg_fwd_inv, 1'b0);
    check("arst_scale", cfg_scale_sch, 8'h6A);
    check("arst_valid", cfg_valid, 1'b0);
    check("arst_pending", cfg_pending, 1'b0);
    check("arst_tready", s_axis_config_tready, 1'b0);
    sbq.delete();
    m_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 64; k++) cyc(1'b0, 16'h0, 1'b1, k == 63);
    check("post_rst_valid", cfg_valid, 1'b0);
    check("post_rst_scale", cfg_scale_sch, 8'h6A);
    cyc(1'b1, 16'h00D5, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    check("post_rst_apply", cfg_valid, 1'b1);
    check("post_rst_fwd", cfg_fwd_inv, 1'b1);

    @(posedge clk); #1;
    check("sb_empty", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
